// File: rtl/mul_accumulator.sv
// mul_accumulator: sums a fixed number of 8-bit products per run.
// The FSM steps IDLE -> ACCUM -> HOLD. The finished sum is held in HOLD
// until downstream takes it. A restart can be requested at any time.
module mul_accumulator #(
    parameter int N_TERMS = 4,   // products summed per run (1..15)
    parameter int ACC_W   = 12   // accumulator width (8..16)
) (
    input  logic             iClock,
    input  logic             iReset_n,
    input  logic             iStart,
    input  logic [7:0]       iProduct,
    input  logic             iValid,
    output logic             oReady,
    output logic [ACC_W-1:0] oSum,
    output logic             oSumValid,
    input  logic             iSumReady,
    output logic [3:0]       oCount,
    output logic             oOverflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'(N_TERMS);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] sum_q, sum_d;
    logic [3:0]       count_q, count_d;
    logic             ovf_q, ovf_d;

    // One extra bit on the adder captures the carry out of the accumulator.
    logic [ACC_W:0]   add_w;
    logic [3:0]       count_inc_w;
    logic             accept_w;

    assign add_w       = {1'b0, sum_q} + {{(ACC_W - 7){1'b0}}, iProduct};
    assign count_inc_w = count_q + 4'd1;
    // The handshake uses only registered state, so oReady never depends on iValid.
    assign accept_w    = (state_q == S_ACCUM) && iValid && !iStart;

    // Next-state and datapath update. iStart always wins and clears the run.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_ACCUM;
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            end
            S_ACCUM: begin
                if (iStart) begin
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (accept_w) begin
                    sum_d   = add_w[ACC_W-1:0];
                    count_d = count_inc_w;
                    ovf_d   = ovf_q | add_w[ACC_W];
                    if (count_inc_w == LAST_COUNT) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (iStart) begin
                    state_d = S_ACCUM;
                    sum_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end else if (iSumReady) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset acts asynchronously and returns everything to zero.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign oReady    = (state_q == S_ACCUM);
    assign oSumValid = (state_q == S_HOLD);
    assign oSum      = sum_q;
    assign oCount    = count_q;
    assign oOverflow = ovf_q;

endmodule

// File: tb/tb_mul_accumulator.sv
// Testbench for mul_accumulator. Three instances receive the same inputs:
// (N=4, W=12), (N=4, W=9) and (N=1, W=12).
// A run-level reference model predicts the outputs of each instance.
module tb_mul_accumulator;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] prod;
    logic       valid;
    logic       sready;

    logic        rdy0, rdy1, rdy2;
    logic        sv0, sv1, sv2;
    logic        ov0, ov1, ov2;
    logic [3:0]  cnt0, cnt1, cnt2;
    logic [11:0] sum0;
    logic [8:0]  sum1;
    logic [11:0] sum2;

    int checks   = 0;
    int failures = 0;

    // Parameters of each instance, as seen by the model.
    int P_N [3] = '{4, 4, 1};
    int P_W [3] = '{12, 9, 12};

    // Model per instance: 0 = waiting for start, 1 = run open, 2 = result held.
    int m_phase [3];
    int m_sum   [3];
    int m_cnt   [3];
    int m_ovf   [3];

    mul_accumulator #(.N_TERMS(4), .ACC_W(12)) dut0 (
        .iClock(clk), .iReset_n(rst_n), .iStart(start), .iProduct(prod),
        .iValid(valid), .oReady(rdy0), .oSum(sum0), .oSumValid(sv0),
        .iSumReady(sready), .oCount(cnt0), .oOverflow(ov0));

    mul_accumulator #(.N_TERMS(4), .ACC_W(9)) dut1 (
        .iClock(clk), .iReset_n(rst_n), .iStart(start), .iProduct(prod),
        .iValid(valid), .oReady(rdy1), .oSum(sum1), .oSumValid(sv1),
        .iSumReady(sready), .oCount(cnt1), .oOverflow(ov1));

    mul_accumulator #(.N_TERMS(1), .ACC_W(12)) dut2 (
        .iClock(clk), .iReset_n(rst_n), .iStart(start), .iProduct(prod),
        .iValid(valid), .oReady(rdy2), .oSum(sum2), .oSumValid(sv2),
        .iSumReady(sready), .oCount(cnt2), .oOverflow(ov2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_phase[k] = 0; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
        end
    endtask

    // Apply one clock edge's worth of run rules to every model instance.
    task automatic model_step(input bit st, input bit v, input int p, input bit sr);
        int s;
        for (int k = 0; k < 3; k++) begin
            if (st) begin
                m_phase[k] = 1; m_sum[k] = 0; m_cnt[k] = 0; m_ovf[k] = 0;
            end else if (m_phase[k] == 1 && v) begin
                s = m_sum[k] + p;
                if (s >= (1 << P_W[k])) m_ovf[k] = 1;
                m_sum[k] = s % (1 << P_W[k]);
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == P_N[k]) m_phase[k] = 2;
            end else if (m_phase[k] == 2 && sr) begin
                m_phase[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("d0_sum",   int'(sum0), m_sum[0]);
        chk("d0_count", int'(cnt0), m_cnt[0]);
        chk("d0_ovf",   int'(ov0),  m_ovf[0]);
        chk("d0_ready", int'(rdy0), int'(m_phase[0] == 1));
        chk("d0_sval",  int'(sv0),  int'(m_phase[0] == 2));
        chk("d1_sum",   int'(sum1), m_sum[1]);
        chk("d1_count", int'(cnt1), m_cnt[1]);
        chk("d1_ovf",   int'(ov1),  m_ovf[1]);
        chk("d1_ready", int'(rdy1), int'(m_phase[1] == 1));
        chk("d1_sval",  int'(sv1),  int'(m_phase[1] == 2));
        chk("d2_sum",   int'(sum2), m_sum[2]);
        chk("d2_count", int'(cnt2), m_cnt[2]);
        chk("d2_ovf",   int'(ov2),  m_ovf[2]);
        chk("d2_ready", int'(rdy2), int'(m_phase[2] == 1));
        chk("d2_sval",  int'(sv2),  int'(m_phase[2] == 2));
    endtask

    // Drive one cycle, advance the model, and compare just after the edge.
    task automatic step(input bit st, input bit v, input int p, input bit sr);
        start = st; valid = v; prod = 8'(p); sready = sr;
        model_step(st, v, p, sr);
        @(posedge clk);
        #1;
        $display("step start=%0b valid=%0b prod=%0d sready=%0b sum0=%0d cnt0=%0d sum1=%0d ovf1=%0b sum2=%0d",
                 st, v, p, sr, sum0, cnt0, sum1, ov1, sum2);
        check_all();
    endtask

    initial begin
        start = 1'b0; valid = 1'b0; prod = 8'd0; sready = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // Input presented in IDLE is ignored.
        step(0, 1, 99, 0);
        step(0, 1, 99, 0);
        chk("idle_count", int'(cnt0), 0);

        // Basic run: 15 + 30 + 45 + 60 = 150. W=9 sees no wrap either.
        step(1, 0, 0, 0);
        step(0, 1, 15, 0);
        step(0, 1, 30, 0);
        step(0, 1, 45, 0);
        step(0, 1, 60, 0);
        chk("basic_sum", int'(sum0), 150);
        chk("basic_sval", int'(sv0), 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        chk("basic_idle_sval", int'(sv0), 0);

        // Overflow run: four products of 225. W=9 wraps on the 3rd acceptance.
        step(1, 0, 0, 0);
        step(0, 1, 225, 0);
        step(0, 1, 225, 0);
        chk("ovf_before_3rd", int'(ov1), 0);
        step(0, 1, 225, 0);
        chk("ovf_after_3rd", int'(ov1), 1);
        step(0, 1, 225, 0);
        chk("ovf_sum_w9", int'(sum1), 388);
        chk("ovf_sum_w12", int'(sum0), 900);
        step(0, 0, 0, 1);

        // Accept only on cycles where valid is asserted. The pattern is 1,0,0,1,0,1,1.
        step(1, 0, 0, 0);
        step(0, 1, 10, 0);
        step(0, 0, 10, 0);
        step(0, 0, 10, 0);
        step(0, 1, 10, 0);
        step(0, 0, 10, 0);
        step(0, 1, 10, 0);
        step(0, 1, 10, 0);
        chk("gaps_sum", int'(sum0), 40);
        step(0, 0, 0, 1);

        // Restart mid-run. The 77 presented together with start is discarded.
        step(1, 0, 0, 0);
        step(0, 1, 50, 0);
        step(0, 1, 50, 0);
        step(1, 1, 77, 0);
        step(0, 1, 1, 0);
        step(0, 1, 2, 0);
        step(0, 1, 3, 0);
        step(0, 1, 4, 0);
        chk("restart_sum", int'(sum0), 10);
        chk("restart_count", int'(cnt0), 4);

        // Back-pressure. Then start and sready arrive together.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 5, 0);
            chk("hold_stable", int'(sum0), 10);
        end
        step(1, 0, 0, 1);
        chk("b2b_sum", int'(sum0), 0);
        chk("b2b_sval", int'(sv0), 0);
        chk("b2b_ready", int'(rdy0), 1);

        // Asynchronous reset after two acceptances, applied between edges.
        step(0, 1, 20, 0);
        step(0, 1, 20, 0);
        @(negedge clk);
        start = 1'b0; valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        #1;
        rst_n = 1'b1;
        step(0, 1, 7, 0);
        step(1, 0, 0, 0);
        step(0, 1, 8, 0);
        chk("post_reset_sum", int'(sum0), 8);

        // Randomized traffic. Start is issued now and then; all else is random.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 15) == 0), 1'($urandom), int'($urandom_range(0, 255)),
                 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
